// File: rtl/mmu_arbiter_pkg.sv
// Shared types for the MMU port arbiter: exception codes and arbiter FSM states.
package mmu_arbiter_pkg;

  typedef enum logic [1:0] {
    MMU_EXC_NONE         = 2'd0,
    MMU_EXC_PAGE_FAULT   = 2'd1,
    MMU_EXC_ACCESS_FAULT = 2'd2,
    MMU_EXC_MISALIGNED   = 2'd3
  } mmu_exception_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOOKUP = 2'd1,
    ARB_RESP   = 2'd2
  } mmu_arb_state_e;

endpackage

// File: rtl/mmu_arbiter_if.sv
// Bundle of the requester, response and MMU-side signals around mmu_arbiter.
interface mmu_arbiter_if
  import mmu_arbiter_pkg::*;
#(
  parameter int unsigned VPN_W = 36,
  parameter int unsigned PFN_W = 6
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [VPN_W-1:0] req_vpn [2];
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [PFN_W-1:0] resp_pfn;
  mmu_exception_e   resp_exception;
  logic [VPN_W-1:0] mmu_vpn;
  logic [PFN_W-1:0] mmu_pfn;
  mmu_exception_e   mmu_exception;

  // Requester/MMU side drives requests and lookup results.
  modport master (
    output req_valid, req_vpn, resp_ready, mmu_pfn, mmu_exception,
    input  req_ready, resp_valid, resp_pfn, resp_exception, mmu_vpn
  );

  modport slave (
    input  req_valid, req_vpn, resp_ready, mmu_pfn, mmu_exception,
    output req_ready, resp_valid, resp_pfn, resp_exception, mmu_vpn
  );
endinterface

// File: rtl/mmu_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant; rr_i names the requester favoured on a tie.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       rr_i,
  output logic [1:0] grant_o
);
  assign grant_o[0] = valid_i[0] & (~valid_i[1] | ~rr_i);
  assign grant_o[1] = valid_i[1] & (~valid_i[0] |  rr_i);
endmodule

// File: rtl/mmu_arbiter.sv
// Shares one MMU translation port between instruction fetch (port 0) and load/store (port 1).
module mmu_arbiter
  import mmu_arbiter_pkg::*;
#(
  parameter int unsigned PHYS_MEM_SIZE = 18,
  parameter int unsigned PAGESIZE      = 12,
  parameter int unsigned VADDR_SIZE    = 48,
  parameter int unsigned MMU_LATENCY   = 1
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [1:0]                       req_valid_in,
  output logic [1:0]                       req_ready_out,
  input  logic [VADDR_SIZE-PAGESIZE-1:0]   req_vpn_in [2],
  output logic [1:0]                       resp_valid_out,
  input  logic [1:0]                       resp_ready_in,
  output logic [PHYS_MEM_SIZE-PAGESIZE-1:0] resp_pfn_out,
  output mmu_exception_e                   resp_exception_out,
  output logic [VADDR_SIZE-PAGESIZE-1:0]   mmu_vpn_out,
  input  logic [PHYS_MEM_SIZE-PAGESIZE-1:0] mmu_pfn_in,
  input  mmu_exception_e                   mmu_exception_in
);
  localparam int unsigned VPN_W = VADDR_SIZE - PAGESIZE;
  localparam int unsigned PFN_W = PHYS_MEM_SIZE - PAGESIZE;
  localparam int unsigned CNT_W = $clog2(MMU_LATENCY + 1);

  mmu_arb_state_e   state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic [PFN_W-1:0] pfn_q, pfn_d;
  mmu_exception_e   exc_q, exc_d;
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [1:0]       grant;

  rr_arbiter2 u_rr_arbiter2 (
    .valid_i (req_valid_in),
    .rr_i    (rr_q),
    .grant_o (grant)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ARB_IDLE;
      rr_q         <= 1'b0;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      vpn_q        <= '0;
      pfn_q        <= '0;
      exc_q        <= MMU_EXC_NONE;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      vpn_q        <= vpn_d;
      pfn_q        <= pfn_d;
      exc_q        <= exc_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next-state logic; grant implies valid, so any grant in IDLE is a handshake.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    vpn_d         = vpn_q;
    pfn_d         = pfn_q;
    exc_d         = exc_q;
    resp_valid_d  = resp_valid_q;
    req_ready_out = '0;
    case (state_q)
      ARB_IDLE: begin
        req_ready_out = grant;
        if (|grant) begin
          vpn_d   = grant[1] ? req_vpn_in[1] : req_vpn_in[0];
          owner_d = grant[1];
          rr_d    = ~grant[1];
          cnt_d   = '0;
          state_d = ARB_LOOKUP;
        end
      end
      ARB_LOOKUP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MMU_LATENCY - 1)) begin
          exc_d        = mmu_exception_in;
          pfn_d        = (mmu_exception_in == MMU_EXC_NONE) ? mmu_pfn_in : '0;
          resp_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d      = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (resp_ready_in[owner_q]) begin
          resp_valid_d = '0;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign resp_valid_out     = resp_valid_q;
  assign resp_pfn_out       = pfn_q;
  assign resp_exception_out = exc_q;
  assign mmu_vpn_out        = vpn_q;

endmodule
